instruction_decode_pipe: RTL

INSTRUCTION_DECODE_PIPE -- requirements
Module: instruction_decode_pipe

---
 rtl/instruction_decode_pipe.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_decode_pipe.sv
// ID stage: register file with write bypass, hazard detection, branch/jump resolution, ID/EX register.
// Optional debug port (dbg_freeze/dbg_addr/dbg_data) is enabled by defining DEBUG_PORT_EN.
module instruction_decode_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    localparam int unsigned REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [31:0]       if_instr,
    input  logic              id_flush,
    input  logic              ex_stall,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_reg_write,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              id_ready,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              ex_valid,
    output logic [8:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rega,
    output logic [DATA_W-1:0] ex_regb,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd
`ifdef DEBUG_PORT_EN
    ,
    input  logic              dbg_freeze,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] FnJr    = 6'h08;

    logic [DATA_W-1:0] regs [NREG];
    logic              rfWe;
    logic              holdIdEx;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] pc4;
    logic [8:0]        ctrl;
    logic              isBranch;
    logic              isJr;
    logic              loadUse;
    logic              branchStall;
    logic              bubble;

    assign op    = if_instr[31:26];
    assign funct = if_instr[5:0];
    assign rs    = if_instr[21+REG_AW-1:21];
    assign rt    = if_instr[16+REG_AW-1:16];
    assign rd    = if_instr[11+REG_AW-1:11];

`ifdef DEBUG_PORT_EN
    assign rfWe     = wb_we && !dbg_freeze;
    assign holdIdEx = ex_stall || dbg_freeze;
`else
    assign rfWe     = wb_we;
    assign holdIdEx = ex_stall;
`endif

    // Same-cycle write-back is forwarded so ID never sees a stale register.
    function automatic logic [DATA_W-1:0] readReg(input logic [REG_AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        if (rfWe && wb_waddr == addr) begin
            return wb_wdata;
        end
        return regs[addr];
    endfunction

    assign rsVal = readReg(rs);
    assign rtVal = readReg(rt);

`ifdef DEBUG_PORT_EN
    assign dbg_data = readReg(dbg_addr);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (rfWe && wb_waddr != '0) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    // Control word {EXE[3:0], MEM[2:0], WB[1:0]}:
    // EXE = {RegDst, ALUOp[1:0], ALUSrc}, MEM = {Branch, MemRead, MemWrite}, WB = {RegWrite, MemtoReg}.
    always_comb begin
        ctrl = '0;
        case (op)
            6'h00: begin
                if (funct != FnJr) begin
                    ctrl = 9'b1100_000_10;
                end
            end
            6'h23:                      ctrl = 9'b0001_010_11;
            6'h2B:                      ctrl = 9'b0001_001_00;
            6'h04, 6'h05:               ctrl = 9'b0010_100_00;
            6'h08, 6'h09:               ctrl = 9'b0001_000_10;
            6'h0A, 6'h0B, 6'h0C, 6'h0D,
            6'h0E, 6'h0F:               ctrl = 9'b0111_000_10;
            default:                    ctrl = '0;
        endcase
    end

    assign simm = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

    always_comb begin
        imm = simm;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            imm = {{(DATA_W-16){1'b0}}, if_instr[15:0]};
        end else if (op == 6'h0F) begin
            imm = DATA_W'({if_instr[15:0], 16'h0000});
        end
    end

    assign isBranch = (op == OpBeq) || (op == OpBne);
    assign isJr     = (op == OpRType) && (funct == FnJr);

    assign loadUse = if_valid && ex_mem_read && (ex_dst != '0) &&
                     ((ex_dst == rs) || (ex_dst == rt));

    // Branches resolve in ID, so any in-flight producer of an operand must drain first.
    assign branchStall = if_valid && (isBranch || isJr) &&
        ((ex_reg_write && (ex_dst != '0) && ((ex_dst == rs) || (ex_dst == rt))) ||
         (mem_reg_write && (mem_dst != '0) && ((mem_dst == rs) || (mem_dst == rt))));

    assign id_ready = !holdIdEx && !loadUse && !branchStall;
    assign bubble   = loadUse || branchStall || id_flush || !if_valid;
    assign pc4      = if_pc + DATA_W'(4);

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (if_valid && id_ready && !id_flush) begin
            if ((op == OpBeq && rsVal == rtVal) || (op == OpBne && rsVal != rtVal)) begin
                redirect    = 1'b1;
                redirect_pc = pc4 + (simm << 2);
            end else if (op == OpJ) begin
                redirect    = 1'b1;
                redirect_pc = {pc4[DATA_W-1:28], if_instr[25:0], 2'b00};
            end else if (isJr) begin
                redirect    = 1'b1;
                redirect_pc = rsVal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
            ex_rega  <= '0;
            ex_regb  <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else if (!holdIdEx) begin
            ex_valid <= !bubble;
            ex_ctrl  <= bubble ? 9'd0 : ctrl;
            ex_pc    <= if_pc;
            ex_rega  <= rsVal;
            ex_regb  <= rtVal;
            ex_imm   <= imm;
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_rd    <= rd;
        end
    end

endmodule
